// File: rtl/mult_lut_seq_pkg.sv
// mult_lut_seq_pkg: shared state encodings, default width and radix-4 digit codes
package mult_lut_seq_pkg;
  localparam int DEFAULT_WIDTH = 16;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;
  localparam logic [1:0] DIG_X0 = 2'd0;
  localparam logic [1:0] DIG_X1 = 2'd1;
  localparam logic [1:0] DIG_X2 = 2'd2;
  localparam logic [1:0] DIG_X3 = 2'd3;
endpackage

// File: rtl/mult_lut_digit.sv
// mult_lut_digit: radix-4 partial product select {0, A, 2A, 3A}
module mult_lut_digit import mult_lut_seq_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] A,
  input  logic [1:0]         digit,
  output logic [2*WIDTH-1:0] pp
);
  always_comb pp = digit == DIG_X1 ? A :
                   digit == DIG_X2 ? A << 1 :
                   digit == DIG_X3 ? (A << 1) + A : '0;
endmodule

// File: rtl/mult_lut_seq.sv
// mult_lut_seq: sequential radix-4 LUT multiplier with early exit; MULT_LUT_SIGNED_EN selects two's complement operands
module mult_lut_seq import mult_lut_seq_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic [WIDTH-1:0]   iDato_A,
  input  logic [WIDTH-1:0]   iDato_B,
  output logic               oBusy,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oResult
);
  state_e state_q, state_d;
  logic [2*WIDTH-1:0] a_q, a_d, acc_q, acc_d, pp;
  logic [WIDTH-1:0] b_q, b_d, mag_a, mag_b;
  logic accept;
  assign accept = iStart && state_q != ST_RUN;
`ifdef MULT_LUT_SIGNED_EN
  logic sign_q, sign_d;
  assign mag_a = iDato_A[WIDTH-1] ? -iDato_A : iDato_A;
  assign mag_b = iDato_B[WIDTH-1] ? -iDato_B : iDato_B;
  assign sign_d = accept ? iDato_A[WIDTH-1] ^ iDato_B[WIDTH-1] : sign_q;
  assign oResult = sign_q ? -acc_q : acc_q;
  always_ff @(posedge Clock)
    sign_q <= Reset ? 1'b0 : sign_d;
`else
  assign mag_a = iDato_A;
  assign mag_b = iDato_B;
  assign oResult = acc_q;
`endif
  mult_lut_digit #(.WIDTH(WIDTH)) u_digit (.A(a_q), .digit(b_q[1:0]), .pp(pp));
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    if (accept) begin
      state_d = ST_RUN;
      a_d = {{WIDTH{1'b0}}, mag_a};
      b_d = mag_b;
      acc_d = '0;
    end else if (state_q == ST_RUN) begin
      acc_d = acc_q + pp;
      a_d = a_q << 2;
      b_d = b_q >> 2;
      state_d = (b_q >> 2) == '0 ? ST_DONE : ST_RUN;
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
    end
  end
  assign oBusy = state_q == ST_RUN;
  assign oDone = state_q == ST_DONE;
endmodule

// File: tb/tb_mult_lut_seq.sv
// tb_mult_lut_seq: scoreboard bench for mult_lut_seq against a plain-arithmetic product/latency model
module tb_mult_lut_seq;
  localparam int W = 16;
  typedef struct {
    logic [2*W-1:0] res;
    int k;
    int c0;
  } exp_t;
  logic Clock = 1'b0;
  logic Reset, iStart, oBusy, oDone;
  logic [W-1:0] iDato_A, iDato_B;
  logic [2*W-1:0] oResult;
  exp_t sb[$];
  int n_cmp = 0, n_fail = 0, cyc = 0, busy_cnt = 0;
  mult_lut_seq #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iDato_A(iDato_A), .iDato_B(iDato_B),
    .oBusy(oBusy), .oDone(oDone), .oResult(oResult)
  );
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
`ifdef MULT_LUT_SIGNED_EN
    return v[W-1] ? -v : v;
`else
    return v;
`endif
  endfunction
  function automatic int kdig(input logic [W-1:0] b);
    logic [W-1:0] bm = mag(b);
    int k = 1;
    for (int i = 1; i < W / 2; i++) if ((bm >> (2 * i)) != 0) k = i + 1;
    return k;
  endfunction
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
`ifdef MULT_LUT_SIGNED_EN
    p = longint'($signed(a)) * longint'($signed(b));
`else
    p = longint'(a) * longint'(b);
`endif
    return p[2*W-1:0];
  endfunction
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.res = model(a, b);
    e.k = kdig(b);
    e.c0 = cyc + 1;
    sb.push_back(e);
    iStart = 1'b1;
    iDato_A = a;
    iDato_B = b;
    @(negedge Clock);
    iStart = 1'b0;
  endtask
  task automatic wait_done();
    int t = 0;
    while (!oDone && t < W) begin
      @(negedge Clock);
      t++;
    end
    if (!oDone) check("done_timeout", 64'd0, 64'd1);
  endtask
  always begin
    exp_t e;
    @(posedge Clock);
    #1;
    if (Reset) busy_cnt = 0;
    else begin
      if (oBusy) busy_cnt++;
      if (oDone) begin
        check("busy_in_done", 64'(oBusy), 64'd0);
        if (sb.size() == 0) check("spurious_done", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          check("result", 64'(oResult), 64'(e.res));
          check("latency", 64'(cyc - e.c0), 64'(e.k));
          check("busy_cycles", 64'(busy_cnt), 64'(e.k));
        end
        busy_cnt = 0;
      end
    end
  end
  initial begin
    Reset = 1'b1;
    iStart = 1'b0;
    iDato_A = '0;
    iDato_B = '0;
    repeat (3) @(negedge Clock);
    check("rst_busy", 64'(oBusy), 64'd0);
    check("rst_done", 64'(oDone), 64'd0);
    check("rst_result", 64'(oResult), 64'd0);
    Reset = 1'b0;
    @(negedge Clock);
    issue(16'd3, 16'd5);
    wait_done();
    issue(16'h1234, 16'h0000);
    wait_done();
    issue(16'hFFFF, 16'hFFFF);
    wait_done();
    @(negedge Clock);
    issue(16'd2, 16'h8000);
    @(negedge Clock);
    iStart = 1'b1;
    iDato_A = 16'd9;
    iDato_B = 16'd9;
    @(negedge Clock);
    iStart = 1'b0;
    wait_done();
    repeat (2) @(negedge Clock);
    check("hold_result", 64'(oResult), 64'(model(16'd2, 16'h8000)));
    issue(16'hFFFD, 16'd7);
    wait_done();
    issue(16'h8000, 16'h8000);
    wait_done();
    @(negedge Clock);
    issue(16'hFFFF, 16'h7FFF);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    sb.delete();
    @(negedge Clock);
    check("midrst_busy", 64'(oBusy), 64'd0);
    check("midrst_done", 64'(oDone), 64'd0);
    check("midrst_result", 64'(oResult), 64'd0);
    Reset = 1'b0;
    repeat (W) @(negedge Clock);
    issue(16'd3, 16'd5);
    wait_done();
    for (int i = 0; i < 200; i++) begin
      issue(W'($urandom), W'($urandom) >> $urandom_range(0, W - 1));
      wait_done();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge Clock);
    end
    repeat (W) @(negedge Clock);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_lut_seq.md
# mult_lut_seq

Sequential, parametrised radix-4 LUT multiplier. Each cycle it consumes one 2-bit digit of the multiplier and adds one of {0, A, 2A, 3A} to a shifting accumulator. It replaces the fully unrolled 16×16 LUT multiplier tree in datapaths where area matters more than latency. It provides a start/busy/done handshake, early termination on exhausted multiplier digits, and an optional signed mode.

## Interface
- WIDTH, 16, operand width in bits; must be even and ≥ 4.
- Clock  in  1  single system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- iStart  in  1  request pulse; sampled on the rising edge of Clock.
- iDato_A  in  WIDTH  multiplicand; captured when the start is accepted.
- iDato_B  in  WIDTH  multiplier; captured when the start is accepted.
- oBusy  out  1  high while the operation is in state RUN.
- oDone  out  1  one-cycle pulse; oResult is valid in this cycle.
- oResult  out  2*WIDTH  product; held until the next accepted start.

## Operation
- The FSM has three states: IDLE, RUN, DONE. The state after reset is IDLE.
- **Accepting a start:** iStart is accepted in IDLE or in DONE.
  - On acceptance: A_reg ← iDato_A zero-extended to 2*WIDTH; B_reg ← iDato_B; acc ← 0; state → RUN.
- **Start in RUN:** iStart is ignored. No state change and no error flag.
- **Each RUN edge:**
  - acc ← acc + digit_pp(A_reg, B_reg[1:0]), where digit_pp gives 0, A, A<<1, or (A<<1)+A.
  - A_reg ← A_reg << 2; B_reg ← B_reg >> 2.
- **Early exit:** if B_reg >> 2 == 0 on a RUN edge, state → DONE. Otherwise the state stays RUN.
  - B = 0 therefore still takes exactly one RUN edge.
- **DONE:** lasts exactly one cycle. oDone = 1 and oBusy = 0. Next state is IDLE, or RUN if iStart is high.
- **Arithmetic:** all additions are 2*WIDTH wide, unsigned, and cannot overflow, since max (2^W−1)² < 2^(2W).
- **Output:** oResult is driven from registers only (acc, plus the sign register when signed mode is compiled in). There are no combinational paths from the inputs.
- **Reset in any state, including mid-RUN:** state → IDLE; acc, A_reg, B_reg and the sign register → 0. The in-flight operation is discarded and oDone is not pulsed.
- **Reset values:** oBusy = 0, oDone = 0, oResult = 0.

## Timing
- Let k = number of radix-4 digits up to the most-significant set bit of iDato_B, with k = 1 when B = 0. The range is 1 ≤ k ≤ WIDTH/2.
- The start is accepted at edge E0. RUN occupies edges E1..Ek−1 as observed by the outputs. oBusy is high for k cycles after E0.
- The final digit is added at edge Ek, and DONE is entered at the same edge. oDone is high in the cycle following Ek.
- Start-to-done latency is k cycles after the accept edge: 1 cycle minimum, WIDTH/2 maximum.
- Back-to-back operation: holding iStart high through DONE gives throughput of one result per k+1 cycles with no bubble into IDLE.

## Configuration
- MULT_LUT_SIGNED_EN
  - **Defined:** operands are two's complement.
    - At accept, the sign register ← iDato_A[MSB] ^ iDato_B[MSB], and A_reg/B_reg are loaded with the operand magnitudes.
    - The most negative value, −2^(W−1), has magnitude 2^(W−1), which fits in WIDTH unsigned bits.
    - oResult = sign ? −acc : acc, computed in 2*WIDTH two's complement from registered values.
    - Latency is unchanged. k is computed from |B|.
  - **Undefined:** operands are unsigned. No sign register is built, and oResult = acc.

## Structure
- Defintions.v holds:
  - the state encodings (ST_IDLE, ST_RUN, ST_DONE);
  - the default WIDTH constant;
  - the digit-select encodings shared with the existing combinational LUT multipliers.
- One sub-module: mult_lut_digit. It is combinational, with parameter WIDTH, inputs A (2*WIDTH) and digit (2 bits), and output pp (2*WIDTH). It is instantiated once in the RUN datapath.

## Test plan
- Unsigned, WIDTH = 16: A = 3, B = 5 → oDone 2 cycles after accept, oResult = 0x0000000F, oBusy high for 2 cycles.
- A = 0x1234, B = 0 → oDone 1 cycle after accept, oResult = 0.
- A = 0xFFFF, B = 0xFFFF → oDone 8 cycles after accept, oResult = 0xFFFE0001.
- Start during RUN: accept A = 2, B = 0x8000; pulse iStart with A = 9, B = 9 two cycles later → it is ignored, and oResult = 0x00010000 after 8 cycles.
- Reset mid-op: Reset asserted 3 cycles into a 0xFFFF×0xFFFF run → next cycle oBusy = 0, oResult = 0, no oDone pulse. A new start afterwards completes normally.
- With MULT_LUT_SIGNED_EN: −3 × 7 → oResult = 0xFFFFFFEB. 0x8000 × 0x8000 → oResult = 0x40000000 after 8 cycles.
